// File: rtl/cmd_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : cmd_seq_checker
// Brief    : Table-driven command sequencer/checker for the RemoteComm link.
//            Sends each stored command, waits for cmd_snt and a response
//            byte under a programmable timeout, and compares the response
//            against the stored expected value. Reports pass, or the index
//            and cause of the first failure.
// Options  : define CMD_SEQ_RETRY_EN to re-issue an entry once after a send
//            or response timeout; this also adds the retry_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_seq_checker #(
    parameter int DEPTH  = 8,
    parameter int CMD_W  = 16,
    parameter int RESP_W = 8,
    parameter int TO_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [CMD_W-1:0]         wr_cmd,
    input  logic [RESP_W-1:0]        wr_exp,
    input  logic [$clog2(DEPTH):0]   num_cmds,
    input  logic [TO_W-1:0]          timeout,
    input  logic                     start,
    output logic [CMD_W-1:0]         cmd,
    output logic                     snd_cmd,
    input  logic                     cmd_snt,
    input  logic                     resp_rdy,
    input  logic [RESP_W-1:0]        resp,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [1:0]               fail_code
`ifdef CMD_SEQ_RETRY_EN
    ,
    output logic [$clog2(DEPTH):0]   retry_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]     c_depth_n = (AW+1)'(DEPTH);
    localparam logic [AW:0]     c_n_one   = (AW+1)'(1);
    localparam logic [AW-1:0]   c_idx_one = AW'(1);
    localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);

    localparam logic [1:0] c_fc_none = 2'b00;
    localparam logic [1:0] c_fc_snt  = 2'b01;
    localparam logic [1:0] c_fc_resp = 2'b10;
    localparam logic [1:0] c_fc_mis  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_SNT  = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_CHECK     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t              state_q,     state_d;
    logic [CMD_W-1:0]    cmd_q,       cmd_d;
    logic                snd_cmd_q,   snd_cmd_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                pass_q,      pass_d;
    logic [AW-1:0]       fail_idx_q,  fail_idx_d;
    logic [1:0]          fail_code_q, fail_code_d;
    logic [AW-1:0]       idx_q,       idx_d;
    logic [AW:0]         n_q,         n_d;
    logic [TO_W-1:0]     timer_q,     timer_d;
    logic [RESP_W-1:0]   resp_q,      resp_d;
`ifdef CMD_SEQ_RETRY_EN
    logic                retry_q,     retry_d;
    logic [AW:0]         retry_cnt_q, retry_cnt_d;
`endif

    logic [CMD_W-1:0]    tbl_cmd_q [DEPTH];
    logic [RESP_W-1:0]   tbl_exp_q [DEPTH];

    logic [AW:0]         w_n_lim;
    logic [TO_W-1:0]     w_to_lim;
    logic                w_to_hit;
    logic                w_to_event;
    logic [1:0]          w_to_code;
    logic                w_go_done;

    // Clamp the requested entry count; a zero timeout behaves like one.
    assign w_n_lim  = (num_cmds > c_depth_n) ? c_depth_n : num_cmds;
    assign w_to_lim = (timeout == '0) ? '0 : (timeout - c_to_one);
    assign w_to_hit = (timer_q == w_to_lim);

    // Table write port; writes are locked out while a run is active and
    // the contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            tbl_cmd_q[wr_addr] <= wr_cmd;
            tbl_exp_q[wr_addr] <= wr_exp;
        end
    end

    // Next-state and output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        snd_cmd_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_idx_d  = fail_idx_q;
        fail_code_d = fail_code_q;
        idx_d       = idx_q;
        n_d         = n_q;
        timer_d     = timer_q;
        resp_d      = resp_q;
`ifdef CMD_SEQ_RETRY_EN
        retry_d     = retry_q;
        retry_cnt_d = retry_cnt_q;
`endif
        w_to_event  = 1'b0;
        w_to_code   = c_fc_none;
        w_go_done   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d         = w_n_lim;
                    idx_d       = '0;
                    fail_idx_d  = '0;
                    fail_code_d = c_fc_none;
                    timer_d     = '0;
`ifdef CMD_SEQ_RETRY_EN
                    retry_d     = 1'b0;
                    retry_cnt_d = '0;
`endif
                    if (w_n_lim == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
            end
            S_SEND: begin
                // cmd and snd_cmd are registered, so they appear together
                // one cycle after this state.
                cmd_d     = tbl_cmd_q[idx_q];
                snd_cmd_d = 1'b1;
                timer_d   = '0;
                state_d   = S_WAIT_SNT;
            end
            S_WAIT_SNT: begin
                if (cmd_snt) begin
                    timer_d = '0;
                    state_d = S_WAIT_RESP;
                end else if (w_to_hit) begin
                    w_to_event = 1'b1;
                    w_to_code  = c_fc_snt;
                end else begin
                    timer_d = timer_q + c_to_one;
                end
            end
            S_WAIT_RESP: begin
                // A response arriving on the timeout cycle still counts.
                if (resp_rdy) begin
                    resp_d  = resp;
                    state_d = S_CHECK;
                end else if (w_to_hit) begin
                    w_to_event = 1'b1;
                    w_to_code  = c_fc_resp;
                end else begin
                    timer_d = timer_q + c_to_one;
                end
            end
            S_CHECK: begin
                if (resp_q != tbl_exp_q[idx_q]) begin
                    fail_code_d = c_fc_mis;
                    w_go_done   = 1'b1;
                end else begin
`ifdef CMD_SEQ_RETRY_EN
                    retry_d = 1'b0;
`endif
                    if ({1'b0, idx_q} == (n_q - c_n_one)) begin
                        pass_d    = 1'b1;
                        w_go_done = 1'b1;
                    end else begin
                        idx_d   = idx_q + c_idx_one;
                        state_d = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A timeout either re-issues the entry (once) or ends the run.
        if (w_to_event) begin
`ifdef CMD_SEQ_RETRY_EN
            if (!retry_q) begin
                retry_d     = 1'b1;
                retry_cnt_d = retry_cnt_q + c_n_one;
                timer_d     = '0;
                state_d     = S_SEND;
            end else begin
                fail_code_d = w_to_code;
                w_go_done   = 1'b1;
            end
`else
            fail_code_d = w_to_code;
            w_go_done   = 1'b1;
`endif
        end

        if (w_go_done) begin
            state_d    = S_DONE;
            fail_idx_d = idx_q;
            busy_d     = 1'b0;
            done_d     = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            snd_cmd_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_idx_q  <= '0;
            fail_code_q <= c_fc_none;
            idx_q       <= '0;
            n_q         <= '0;
            timer_q     <= '0;
            resp_q      <= '0;
`ifdef CMD_SEQ_RETRY_EN
            retry_q     <= 1'b0;
            retry_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            snd_cmd_q   <= snd_cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_idx_q  <= fail_idx_d;
            fail_code_q <= fail_code_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            timer_q     <= timer_d;
            resp_q      <= resp_d;
`ifdef CMD_SEQ_RETRY_EN
            retry_q     <= retry_d;
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    assign cmd       = cmd_q;
    assign snd_cmd   = snd_cmd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_idx  = fail_idx_q;
    assign fail_code = fail_code_q;
`ifdef CMD_SEQ_RETRY_EN
    assign retry_cnt = retry_cnt_q;
`endif

endmodule
`default_nettype wire
